// File: rtl/bus_skid_stage_if.sv
// ---------------------------------------------------------------------------
// bus_skid_stage_if
//   One valid/ready handshake lane carrying a WIDTH-bit payload.
//   Signals:
//     valid  producer offers data this cycle
//     ready  consumer accepts data this cycle
//     data   payload
//   Modports:
//     master  drives valid/data, observes ready
//     slave   observes valid/data, drives ready
// ---------------------------------------------------------------------------
interface bus_skid_stage_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bus_skid_stage.sv
// ---------------------------------------------------------------------------
// bus_skid_stage
//   Two-entry registered skid buffer between a producer that may stall and the
//   bus lane.
//   The upstream ready is a flop, so there is no combinational path from the
//   downstream ready back to the producer. Delivered beats are counted in a
//   wrapping counter for debug.
//   Ports:
//     clk         clock, all state on rising edge
//     rst_n       asynchronous active-low reset
//     up          slave lane from the producer (in_valid/in_ready/in_data)
//     dn          master lane to the bus buffer (out_valid/out_ready/out_data)
//     occupancy   beats held: 0, 1 or 2
//     xfer_count  output transfers, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module bus_skid_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bus_skid_stage_if.slave      up,
    bus_skid_stage_if.master     dn,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     xfer_count
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               in_ready_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_fire;
    logic               out_fire;

    assign in_fire  = up.valid & in_ready_q;
    assign out_fire = (state_q != StEmpty) & dn.ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d = StOne;
                    main_d  = up.data;
                end
            end
            StOne: begin
                if (in_fire && out_fire) begin
                    main_d = up.data;
                end else if (in_fire) begin
                    state_d = StFull;
                    skid_d  = up.data;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    state_d = StOne;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            // Registered from next state: held low for the first cycle after reset.
            in_ready_q <= (state_d != StFull);
            if (out_fire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign up.ready   = in_ready_q;
    assign dn.valid   = (state_q != StEmpty);
    assign dn.data    = main_q;
    assign occupancy  = state_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_bus_skid_stage.sv
module tb_bus_skid_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    always #5 clk = ~clk;

    // Two DUTs share stimulus; the second has a 4-bit counter to exercise wrap.
    bus_skid_stage_if #(.WIDTH(8)) a_in ();
    bus_skid_stage_if #(.WIDTH(8)) a_out ();
    bus_skid_stage_if #(.WIDTH(8)) b_in ();
    bus_skid_stage_if #(.WIDTH(8)) b_out ();

    assign a_in.valid  = in_valid;
    assign a_in.data   = in_data;
    assign a_out.ready = out_ready;
    assign b_in.valid  = in_valid;
    assign b_in.data   = in_data;
    assign b_out.ready = out_ready;

    logic [1:0]  occ_a, occ_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    bus_skid_stage #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up         (a_in),
        .dn         (a_out),
        .occupancy  (occ_a),
        .xfer_count (cnt_a)
    );

    bus_skid_stage #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up         (b_in),
        .dn         (b_out),
        .occupancy  (occ_b),
        .xfer_count (cnt_b)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a FIFO of capacity 2 plus a transfer count.
    logic [7:0] q[$];
    int         xfers   = 0;
    bit         started = 0;  // ready only after the first edge out of reset
    bit         accepted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return started && (q.size() < 2);
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, {31'd0, a_out.valid}, {31'd0, q.size() > 0});
        chk({tag, ".in_ready"}, {31'd0, a_in.ready}, {31'd0, model_ready()});
        chk({tag, ".occupancy"}, {30'd0, occ_a}, q.size());
        chk({tag, ".xfer_count"}, {16'd0, cnt_a}, xfers & 32'hFFFF);
        chk({tag, ".xfer_count4"}, {28'd0, cnt_b}, xfers & 32'hF);
        chk({tag, ".occupancy4"}, {30'd0, occ_b}, q.size());
        if (q.size() > 0) begin
            chk({tag, ".out_data"}, {24'd0, a_out.data}, {24'd0, q[0]});
            chk({tag, ".out_data4"}, {24'd0, b_out.data}, {24'd0, q[0]});
        end
    endtask

    task automatic tick(input string tag);
        bit in_f, out_f;
        in_f  = in_valid && model_ready();
        out_f = (q.size() > 0) && out_ready;
        @(posedge clk);
        accepted = 0;
        if (rst_n) begin
            if (out_f) begin
                void'(q.pop_front());
                xfers++;
            end
            if (in_f) begin
                q.push_back(in_data);
                accepted = 1;
            end
            started = 1;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        q.delete();
        xfers   = 0;
        started = 0;
        check_outputs("reset");
        chk("reset.out_data", {24'd0, a_out.data}, 32'h0);
    endtask

    initial begin
        int next;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b0;

        // 1. reset release with a beat waiting
        #12;
        check_outputs("por");
        chk("por.out_data", {24'd0, a_out.data}, 32'h0);
        rst_n = 1'b1;
        tick("rel0");
        chk("rel0.no_accept", {31'd0, a_out.valid}, 32'd0);
        tick("rel1");
        in_valid = 1'b0;
        in_data  = 'x;
        tick("rel2");
        chk("rel.a5", {24'd0, a_out.data}, 32'hA5);

        // 2. streaming 0x01..0x10 with out_ready high
        out_ready = 1'b1;
        next = 1;
        for (int c = 0; c < 40 && next <= 16; c++) begin
            in_valid = 1'b1;
            in_data  = next[7:0];
            tick("stream");
            chk("stream.occ_lt2", {31'd0, occ_a == 2'd2}, 32'd0);
            if (accepted) next++;
        end
        chk("stream.sent", next, 17);
        in_valid = 1'b0;
        in_data  = 'x;
        for (int c = 0; c < 10 && q.size() > 0; c++) tick("stream_drain");
        chk("stream.drained", {31'd0, a_out.valid}, 32'd0);
        // A5 plus 16 streamed beats
        chk("stream.count", {16'd0, cnt_a}, 32'd17);
        chk("wrap.count4", {28'd0, cnt_b}, 32'd1);

        // 3. stall while offering 0x11, 0x22, 0x33
        out_ready = 1'b0;
        next = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (next < 3);
            in_data  = (next == 0) ? 8'h11 : (next == 1) ? 8'h22 : 8'h33;
            tick("stall");
            if (accepted) next++;
        end
        chk("stall.accepted", next, 2);
        chk("stall.occ", {30'd0, occ_a}, 32'd2);
        chk("stall.data", {24'd0, a_out.data}, 32'h11);
        chk("stall.in_ready", {31'd0, a_in.ready}, 32'd0);

        // 4. release the stall, 0x33 still offered
        out_ready = 1'b1;
        for (int c = 0; c < 12 && (next < 3 || q.size() > 0); c++) begin
            in_valid = (next < 3);
            in_data  = (next < 3) ? 8'h33 : 8'hxx;
            tick("release");
            if (accepted) next++;
        end
        chk("release.sent", next, 3);
        chk("release.empty", {31'd0, a_out.valid}, 32'd0);
        in_valid = 1'b0;

        // 5. reset with two beats held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        tick("fill0");
        in_data = 8'hC3;
        tick("fill1");
        tick("fill2");
        chk("fill.occ", {30'd0, occ_a}, 32'd2);
        #2;
        assert_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #6;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) tick("post_reset");
        chk("post_reset.count", {16'd0, cnt_a}, 32'd0);

        // Random traffic against the FIFO model
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = in_valid ? 8'($urandom) : 8'hxx;
            out_ready = ($urandom_range(0, 99) < 55);
            tick("rand");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) tick("rand_drain");
        chk("rand.drained", {31'd0, a_out.valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
